// File: rtl/idct_block_scheduler_pkg.sv
// Shared definitions for the IDCT block scheduler: sequencer state encoding,
// picture segments, block-grid dimensions and SRAM segment bases/strides.
package idct_block_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LI_FETCH = 3'd1,
    ST_LI_CT    = 3'd2,
    ST_MEGA_A   = 3'd3,
    ST_MEGA_B   = 3'd4,
    ST_LO_CS    = 3'd5,
    ST_LO_WS    = 3'd6
  } sched_state_t;

  typedef enum logic [1:0] {
    SEG_Y = 2'd0,
    SEG_U = 2'd1,
    SEG_V = 2'd2
  } seg_t;

  localparam int Y_BLK_COLS   = 40;
  localparam int UV_BLK_COLS  = 20;
  localparam int BLK_ROWS     = 30;
  localparam int TOTAL_BLOCKS = 2400;

  localparam logic [17:0] PRE_Y_BASE = 18'd76800;
  localparam logic [17:0] PRE_U_BASE = 18'd153600;
  localparam logic [17:0] PRE_V_BASE = 18'd192000;
  localparam logic [17:0] OUT_Y_BASE = 18'd0;
  localparam logic [17:0] OUT_U_BASE = 18'd38400;
  localparam logic [17:0] OUT_V_BASE = 18'd57600;

  localparam logic [8:0] PRE_Y_STRIDE  = 9'd320;
  localparam logic [8:0] PRE_UV_STRIDE = 9'd160;
  localparam logic [8:0] OUT_Y_STRIDE  = 9'd160;
  localparam logic [8:0] OUT_UV_STRIDE = 9'd80;

  localparam logic MODE_FETCH = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/idct_block_scheduler_block_addr_gen.sv
// Block pointer {seg, rb, cb} walking Y -> U -> V in row-major order, with the
// SRAM base address and stride of the current block for either the pre-IDCT
// fetch layout (mode = MODE_FETCH) or the post-IDCT write layout (MODE_WRITE).
// Advancing from the final V block leaves the pointer in place and raises
// at_end, so callers can tell "fetched the last block" from "about to fetch it".
module block_addr_gen
  import idct_block_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  input  logic        mode,
  output logic [17:0] base,
  output logic [8:0]  stride,
  output logic        at_end
);

  seg_t        seg;
  logic [4:0]  rb;
  logic [5:0]  cb;
  logic [11:0] blk_idx;
  logic        spent;

  logic        last_col;
  logic        last_row;
  logic        last_blk;
  logic [17:0] rb_w;
  logic [17:0] cb_w;
  logic [17:0] row_off;
  logic [17:0] col_off;
  logic [17:0] seg_base;

  // Wrap points of the block grid for the current segment
  always_comb begin
    last_col = (seg == SEG_Y) ? (cb == 6'(Y_BLK_COLS - 1)) : (cb == 6'(UV_BLK_COLS - 1));
    last_row = (rb == 5'(BLK_ROWS - 1));
    last_blk = (blk_idx == 12'(TOTAL_BLOCKS - 1));
  end

  // Pointer walk: column, then row, then segment; saturates on the last block
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      seg     <= SEG_Y;
      rb      <= '0;
      cb      <= '0;
      blk_idx <= '0;
      spent   <= 1'b0;
    end else if (advance) begin
      if (last_blk) begin
        spent <= 1'b1;
      end else begin
        blk_idx <= blk_idx + 12'd1;
        if (last_col) begin
          cb <= '0;
          if (last_row) begin
            rb  <= '0;
            seg <= (seg == SEG_Y) ? SEG_U : SEG_V;
          end else begin
            rb <= rb + 5'd1;
          end
        end else begin
          cb <= cb + 6'd1;
        end
      end
    end
  end

  // Shift-add address: 2560 = 2^11+2^9, 1280 = 2^10+2^8, 640 = 2^9+2^7
  always_comb begin
    rb_w     = {13'd0, rb};
    cb_w     = {12'd0, cb};
    row_off  = '0;
    col_off  = '0;
    seg_base = '0;
    stride   = '0;
    if (mode == MODE_FETCH) begin
      col_off = cb_w << 3;
      if (seg == SEG_Y) begin
        row_off  = (rb_w << 11) + (rb_w << 9);
        seg_base = PRE_Y_BASE;
        stride   = PRE_Y_STRIDE;
      end else begin
        row_off  = (rb_w << 10) + (rb_w << 8);
        seg_base = (seg == SEG_U) ? PRE_U_BASE : PRE_V_BASE;
        stride   = PRE_UV_STRIDE;
      end
    end else begin
      col_off = cb_w << 2;
      if (seg == SEG_Y) begin
        row_off  = (rb_w << 10) + (rb_w << 8);
        seg_base = OUT_Y_BASE;
        stride   = OUT_Y_STRIDE;
      end else begin
        row_off  = (rb_w << 9) + (rb_w << 7);
        seg_base = (seg == SEG_U) ? OUT_U_BASE : OUT_V_BASE;
        stride   = OUT_UV_STRIDE;
      end
    end
    base = seg_base + row_off + col_off;
  end

  assign at_end = spent;

endmodule

// File: rtl/idct_block_scheduler.sv
// Milestone 2 IDCT sequencer: walks all 2400 blocks (Y, U, V) and overlaps the
// fetch / compute-T / compute-S / write engines in lead-in, megastate A/B and
// lead-out phases. Each phase pulses its engine starts on entry and leaves the
// edge on which every participating engine has reported done.
// Optional build macro M2_SCHED_PERF_EN adds perf_cycles / perf_stall outputs.
module idct_block_scheduler
  import idct_block_scheduler_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic        Done,
  output logic        Busy,
  output logic        fetch_start,
  output logic [17:0] fetch_base,
  output logic [8:0]  fetch_stride,
  input  logic        fetch_done,
  output logic        ct_start,
  input  logic        ct_done,
  output logic        cs_start,
  input  logic        cs_done,
  output logic        ws_start,
  output logic [17:0] ws_base,
  output logic [8:0]  ws_stride,
  input  logic        ws_done
`ifdef M2_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);

  sched_state_t state;
  logic f_flag, t_flag, s_flag, w_flag;
  logic f_set, t_set, s_set, w_set;
  logic phase_exit;
  logic fetch_adv, ws_adv, ptr_clear;
  logic [17:0] fa_base, wa_base;
  logic [8:0]  fa_stride, wa_stride;
  logic        fa_end;
  logic        wa_end_unused;

  // Sticky done view including this cycle's pulse; a done coincident with its own start is dropped
  always_comb begin
    f_set = f_flag | (fetch_done & ~fetch_start);
    t_set = t_flag | (ct_done & ~ct_start);
    s_set = s_flag | (cs_done & ~cs_start);
    w_set = w_flag | (ws_done & ~ws_start);
    case (state)
      ST_LI_FETCH: phase_exit = f_set;
      ST_LI_CT:    phase_exit = t_set;
      ST_MEGA_A:   phase_exit = s_set & f_set;
      ST_MEGA_B:   phase_exit = t_set & w_set;
      ST_LO_CS:    phase_exit = s_set;
      ST_LO_WS:    phase_exit = w_set;
      default:     phase_exit = 1'b0;
    endcase
  end

  assign fetch_adv = phase_exit & ((state == ST_LI_FETCH) || (state == ST_MEGA_A));
  assign ws_adv    = phase_exit & ((state == ST_MEGA_B) || (state == ST_LO_WS));
  assign ptr_clear = phase_exit & (state == ST_LO_WS);

  block_addr_gen u_fetch_ptr (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (ptr_clear),
    .advance (fetch_adv),
    .mode    (MODE_FETCH),
    .base    (fa_base),
    .stride  (fa_stride),
    .at_end  (fa_end)
  );

  block_addr_gen u_write_ptr (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (ptr_clear),
    .advance (ws_adv),
    .mode    (MODE_WRITE),
    .base    (wa_base),
    .stride  (wa_stride),
    .at_end  (wa_end_unused)
  );

  // Phase sequencer with registered start pulses, bases, Busy and Done
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      Done         <= 1'b0;
      Busy         <= 1'b0;
      fetch_start  <= 1'b0;
      ct_start     <= 1'b0;
      cs_start     <= 1'b0;
      ws_start     <= 1'b0;
      fetch_base   <= '0;
      fetch_stride <= '0;
      ws_base      <= '0;
      ws_stride    <= '0;
      f_flag       <= 1'b0;
      t_flag       <= 1'b0;
      s_flag       <= 1'b0;
      w_flag       <= 1'b0;
    end else begin
      Done        <= 1'b0;
      fetch_start <= 1'b0;
      ct_start    <= 1'b0;
      cs_start    <= 1'b0;
      ws_start    <= 1'b0;
      if ((state == ST_IDLE) || phase_exit) begin
        f_flag <= 1'b0;
        t_flag <= 1'b0;
        s_flag <= 1'b0;
        w_flag <= 1'b0;
      end else begin
        f_flag <= f_set;
        t_flag <= t_set;
        s_flag <= s_set;
        w_flag <= w_set;
      end
      case (state)
        ST_IDLE: if (Enable) begin
          state        <= ST_LI_FETCH;
          Busy         <= 1'b1;
          fetch_start  <= 1'b1;
          fetch_base   <= fa_base;
          fetch_stride <= fa_stride;
        end
        ST_LI_FETCH: if (phase_exit) begin
          state    <= ST_LI_CT;
          ct_start <= 1'b1;
        end
        ST_LI_CT: if (phase_exit) begin
          state        <= ST_MEGA_A;
          cs_start     <= 1'b1;
          fetch_start  <= 1'b1;
          fetch_base   <= fa_base;
          fetch_stride <= fa_stride;
        end
        ST_MEGA_A: if (phase_exit) begin
          state     <= ST_MEGA_B;
          ct_start  <= 1'b1;
          ws_start  <= 1'b1;
          ws_base   <= wa_base;
          ws_stride <= wa_stride;
        end
        ST_MEGA_B: if (phase_exit) begin
          cs_start <= 1'b1;
          if (fa_end) begin
            state <= ST_LO_CS;
          end else begin
            state        <= ST_MEGA_A;
            fetch_start  <= 1'b1;
            fetch_base   <= fa_base;
            fetch_stride <= fa_stride;
          end
        end
        ST_LO_CS: if (phase_exit) begin
          state     <= ST_LO_WS;
          ws_start  <= 1'b1;
          ws_base   <= wa_base;
          ws_stride <= wa_stride;
        end
        ST_LO_WS: if (phase_exit) begin
          state <= ST_IDLE;
          Done  <= 1'b1;
          Busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef M2_SCHED_PERF_EN
  // Busy-cycle and half-finished-megastate counters; cleared on start, frozen from Done on
  always_ff @(posedge Clock) begin
    if (Reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if ((state == ST_IDLE) && Enable) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (Busy) perf_cycles <= perf_cycles + 32'd1;
      if (((state == ST_MEGA_A) && (f_flag ^ s_flag)) ||
          ((state == ST_MEGA_B) && (t_flag ^ w_flag)))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
